// File: rtl/day02_pkg.sv
`default_nettype none
// ============================================================================
// Package     : day02_pkg
// Description : Shared constants and the state type for the result printer.
//               This package has no ports. It holds the default value width
//               and digit count, the BCD step-counter width, the ASCII
//               codes, and tx_state_t.
// Revision    : 1.0 - initial release
// ============================================================================
package day02_pkg;

    localparam int VALUE_W = 64;   // default binary input width
    localparam int DIGITS  = 20;   // BCD digits, >= ceil(VALUE_W*log10(2))
    localparam int STEP_W  = 7;    // double-dabble step counter width

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CONVERT = 3'd1,
        LOCATE  = 3'd2,
        SEND    = 3'd3,
        NEWLINE = 3'd4
    } tx_state_t;

endpackage : day02_pkg
`default_nettype wire

// File: rtl/bcd_double_dabble.sv
`default_nettype none
// ============================================================================
// Module      : bcd_double_dabble
// Description : Iterative binary-to-BCD converter (shift / add-3).
//               A start pulse loads the value and clears the BCD register.
//               The converter then performs one step per cycle for VALUE_W
//               cycles. 'last' is high during the final step, so the BCD
//               register is valid on the cycle after 'last'.
// Ports       : Clk    - clock, posedge
//               RstN   - synchronous reset, active-low
//               start  - load request (value sampled same edge)
//               value  - binary input
//               last   - high in the cycle whose edge performs the final step
//               bcd    - packed BCD result, nibble 0 = least significant digit
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_double_dabble #(
    parameter int VALUE_W = day02_pkg::VALUE_W,
    parameter int DIGITS  = day02_pkg::DIGITS
) (
    input  logic                  Clk,
    input  logic                  RstN,
    input  logic                  start,
    input  logic [VALUE_W-1:0]    value,
    output logic                  last,
    output logic [DIGITS*4-1:0]   bcd
);
    import day02_pkg::*;

    logic [VALUE_W-1:0]  bin_q;
    logic [DIGITS*4-1:0] bcd_q;
    logic [DIGITS*4-1:0] bcd_adj;
    logic [STEP_W-1:0]   step_q;
    logic                running_q;

    // Pre-shift correction: any digit >= 5 would become >= 10 after the shift,
    // so adding 3 now makes the shift carry into the next nibble.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    assign last = running_q && (step_q == STEP_W'(VALUE_W - 1));
    assign bcd  = bcd_q;

    always_ff @(posedge Clk) begin
        if (!RstN) begin
            bin_q     <= '0;
            bcd_q     <= '0;
            step_q    <= '0;
            running_q <= 1'b0;
        end else if (start) begin
            bin_q     <= value;
            bcd_q     <= '0;
            step_q    <= '0;
            running_q <= 1'b1;
        end else if (running_q) begin
            {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
            if (last) begin
                step_q    <= '0;
                running_q <= 1'b0;
            end else begin
                step_q    <= step_q + 1'b1;
            end
        end
    end

endmodule : bcd_double_dabble
`default_nettype wire

// File: rtl/result_ascii_tx.sv
`default_nettype none
// ============================================================================
// Module      : result_ascii_tx
// Description : Prints a binary result as an ASCII decimal line.
//               The BCD conversion is followed by leading-zero suppression.
//               The digits are sent MSD first, followed by LF, over a byte
//               valid/ready link.
// Ports       : Clk     - clock, posedge
//               RstN    - synchronous reset, active-low
//               Start   - 1-cycle request, Value sampled same edge
//               Value   - unsigned binary value to print
//               Busy    - a line is in progress (any non-IDLE state)
//               TxData  - ASCII byte
//               TxValid - TxData valid, held until accepted
//               TxReady - sink accepts byte at posedge when TxValid is high
//               Done    - sticky, line fully sent; cleared by next accepted Start
//               Error   - sticky until reset, Start seen while Busy
// Revision    : 1.0 - initial release
// ============================================================================
module result_ascii_tx #(
    parameter int VALUE_W = day02_pkg::VALUE_W,
    parameter int DIGITS  = day02_pkg::DIGITS
) (
    input  logic                Clk,
    input  logic                RstN,
    input  logic                Start,
    input  logic [VALUE_W-1:0]  Value,
    output logic                Busy,
    output logic [7:0]          TxData,
    output logic                TxValid,
    input  logic                TxReady,
    output logic                Done,
    output logic                Error
);
    import day02_pkg::*;

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    tx_state_t           state, state_next;
    logic [IDX_W-1:0]    idx, idx_next;
    logic [IDX_W-1:0]    msd_idx;
    logic [DIGITS*4-1:0] bcd;
    logic [3:0]          digit;
    logic                accept;
    logic                conv_last;
    logic                done_q;
    logic                error_q;

    assign accept = Start && (state == IDLE);

    bcd_double_dabble #(
        .VALUE_W (VALUE_W),
        .DIGITS  (DIGITS)
    ) u_dabble (
        .Clk   (Clk),
        .RstN  (RstN),
        .start (accept),
        .value (Value),
        .last  (conv_last),
        .bcd   (bcd)
    );

    // Highest nonzero nibble wins; an all-zero result leaves index 0 so that
    // a single '0' is printed.
    always_comb begin
        msd_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[i*4 +: 4] != 4'd0) begin
                msd_idx = IDX_W'(i);
            end
        end
    end

    assign digit = bcd[idx*4 +: 4];

    // TxValid and TxData depend only on the registered state and idx. They
    // therefore hold steady while the sink stalls.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        TxValid    = 1'b0;
        TxData     = 8'h00;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_next = CONVERT;
                end
            end
            CONVERT: begin
                if (conv_last) begin
                    state_next = LOCATE;
                end
            end
            LOCATE: begin
                idx_next   = msd_idx;
                state_next = SEND;
            end
            SEND: begin
                TxValid = 1'b1;
                TxData  = ASCII_ZERO + {4'd0, digit};
                if (TxReady) begin
                    if (idx == '0) begin
                        state_next = NEWLINE;
                    end else begin
                        idx_next = idx - 1'b1;
                    end
                end
            end
            NEWLINE: begin
                TxValid = 1'b1;
                TxData  = ASCII_LF;
                if (TxReady) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!RstN) begin
            state   <= IDLE;
            idx     <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            if (accept) begin
                done_q <= 1'b0;
            end else if ((state == NEWLINE) && TxReady) begin
                done_q <= 1'b1;
            end
            // This also covers a Start that coincides with the final LF transfer.
            if (Start && (state != IDLE)) begin
                error_q <= 1'b1;
            end
        end
    end

    assign Busy  = (state != IDLE);
    assign Done  = done_q;
    assign Error = error_q;

endmodule : result_ascii_tx
`default_nettype wire

// File: tb/tb_result_ascii_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_ascii_tx
// Description : Self-checking bench for result_ascii_tx. The expected lines
//               come from plain decimal arithmetic on the input value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_ascii_tx;

    logic        Clk     = 1'b0;
    logic        RstN    = 1'b0;
    logic        Start   = 1'b0;
    logic [63:0] Value   = '0;
    logic        TxReady = 1'b0;
    logic        Busy;
    logic [7:0]  TxData;
    logic        TxValid;
    logic        Done;
    logic        Error;

    int checks  = 0;
    int errors  = 0;
    bit err_exp = 1'b0;

    always #5 Clk = ~Clk;

    result_ascii_tx #(
        .VALUE_W (64),
        .DIGITS  (20)
    ) dut (
        .Clk     (Clk),
        .RstN    (RstN),
        .Start   (Start),
        .Value   (Value),
        .Busy    (Busy),
        .TxData  (TxData),
        .TxValid (TxValid),
        .TxReady (TxReady),
        .Done    (Done),
        .Error   (Error)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   Busy,    0);
        check({tag, "_valid"},  TxValid, 0);
        check({tag, "_data"},   TxData,  0);
        check({tag, "_done"},   Done,    0);
        check({tag, "_error"},  Error,   0);
    endtask

    // Sends one Start and then collects the line.
    // inj_after : if > 0, pulse Start (Value=5) once that many bytes have been sent.
    // rst_after : if > 0, pulse RstN low once that many bytes have been sent, then abort.
    task automatic run_line(input logic [63:0] v, input int ready_pct,
                            input int inj_after, input int rst_after, input bit chk_lat);
        byte unsigned exp_q[$];
        logic [63:0]  t;
        logic [7:0]   held;
        int           cyc, sent, first_valid;
        bit           stall, finished, injected;

        t = v;
        if (t == 0) exp_q.push_front(8'h30);
        while (t != 0) begin
            exp_q.push_front(8'(t % 64'd10) + 8'h30);
            t = t / 64'd10;
        end
        exp_q.push_back(8'h0A);

        @(negedge Clk);
        Value = v;
        Start = 1'b1;
        cyc = 0; sent = 0; first_valid = -1;
        stall = 1'b0; finished = 1'b0; injected = 1'b0; held = 8'h00;

        while (!finished && cyc < 3000) begin
            @(negedge Clk);
            cyc++;
            Start = 1'b0;
            Value = {$urandom(), $urandom()};
            if (cyc == 1) begin
                check("busy_after_start", Busy, 1);
                check("done_cleared", Done, 0);
            end
            if (stall) begin
                check("stall_hold_valid", TxValid, 1);
                check("stall_hold_data", TxData, held);
            end
            if (TxValid && first_valid < 0) first_valid = cyc;
            if (rst_after > 0 && sent == rst_after) begin
                TxReady = 1'b0;
                RstN    = 1'b0;
                @(negedge Clk);
                check_all_zero("midstream_reset");
                RstN    = 1'b1;
                err_exp = 1'b0;
                return;
            end
            if (inj_after > 0 && sent == inj_after && !injected) begin
                Start    = 1'b1;
                Value    = 64'd5;
                injected = 1'b1;
                err_exp  = 1'b1;
            end
            TxReady = ($urandom_range(99) < ready_pct);
            if (TxValid && TxReady) begin
                check("no_extra_byte", sent < exp_q.size(), 1);
                if (sent < exp_q.size()) check("byte", TxData, exp_q[sent]);
                sent++;
                stall = 1'b0;
                if (sent == exp_q.size()) finished = 1'b1;
            end else begin
                stall = TxValid;
                held  = TxData;
            end
        end

        check("line_complete", finished, 1);
        if (chk_lat) check("first_valid_latency", first_valid, 66);
        @(negedge Clk);
        TxReady = 1'b0;
        check("done_after_lf", Done, 1);
        check("idle_after_lf", Busy, 0);
        check("no_valid_after_lf", TxValid, 0);
        check("error_flag", Error, err_exp);
    endtask

    initial begin
        bit          saw;
        logic [63:0] rv;

        // Reset state
        RstN = 1'b0;
        repeat (3) @(negedge Clk);
        check_all_zero("reset");
        RstN = 1'b1;

        run_line(64'd0, 100, 0, 0, 1'b0);
        run_line(64'd1227775554, 100, 0, 0, 1'b1);
        run_line(64'hFFFF_FFFF_FFFF_FFFF, 100, 0, 0, 1'b1);
        run_line(64'd1000000, 30, 0, 0, 1'b0);

        // Start during SEND: ignored, Error sticks, no second line
        run_line(64'd1227775554, 100, 2, 0, 1'b0);
        saw = 1'b0;
        TxReady = 1'b1;
        repeat (100) begin
            @(negedge Clk);
            saw = saw | TxValid;
        end
        TxReady = 1'b0;
        check("no_second_line", saw, 0);
        check("error_sticky", Error, 1);

        // Reset mid-SEND, then a clean line
        run_line(64'd987654321, 100, 0, 3, 1'b0);
        run_line(64'd42, 100, 0, 0, 1'b0);

        // Randomized values and sink throttling
        repeat (6) begin
            rv = {$urandom(), $urandom()} >> $urandom_range(63);
            run_line(rv, $urandom_range(100, 20), 0, 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_result_ascii_tx
`default_nettype wire
